// File: rtl/tone_synth_writer.sv
// Multi-voice tone generator writing mixed samples to the audio_codec write port.
// Optional TONE_SYNTH_STEREO_PAN_EN: per-voice pan into separate left/right mixes.

module tone_synth_voice #(
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               step,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [AMP_W-1:0]   amplitude,
  output logic [15:0]        prod
);
  localparam int PROD_W = AMP_W + 9;

  logic [PHASE_W-1:0]       phase;
  logic [7:0]               t;
  logic signed [8:0]        tri9;
  logic signed [7:0]        s;
  logic signed [PROD_W-1:0] full;

  assign t    = phase[PHASE_W-1 -: 8];
  assign tri9 = t[7] ? 9'sd127 - $signed({1'b0, t[6:0], 1'b0})
                     : $signed({1'b0, t[6:0], 1'b0}) - 9'sd128;

  always_comb begin
    s = '0;
    case (wave_sel)
      2'b00:   s = t[7] ? 8'h80 : 8'h7F;
      2'b01:   s = {~t[7], t[6:0]};
      2'b10:   s = tri9[7:0];
      default: s = '0;
    endcase
    full = s * $signed({1'b0, amplitude});
    prod = en ? 16'(full >>> (AMP_W - 8)) : '0;
  end

  // A disabled voice parks at phase 0 so it restarts cleanly when re-enabled.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)   phase <= '0;
    else if (!en)  phase <= '0;
    else if (step) phase <= phase + phase_inc;
  end
endmodule

module tone_synth_writer #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 24,
  parameter int PHASE_W    = 24,
  parameter int AMP_W      = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
  input  logic [NUM_VOICES*2-1:0]       wave_sel,
  input  logic [NUM_VOICES*AMP_W-1:0]   amplitude,
`ifdef TONE_SYNTH_STEREO_PAN_EN
  input  logic [NUM_VOICES-1:0]         pan,
`endif
  input  logic                          write_ready,
  output logic                          write,
  output logic [DATA_W-1:0]             writedata_left,
  output logic [DATA_W-1:0]             writedata_right,
  output logic                          busy,
  output logic [15:0]                   sample_count
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
  localparam logic signed [ACC_W-1:0] MAXV = 32767;
  localparam logic signed [ACC_W-1:0] MINV = -32768;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SAT, S_HOLD, S_WRITE} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic signed [ACC_W-1:0]       acc_l;
`ifdef TONE_SYNTH_STEREO_PAN_EN
  logic signed [ACC_W-1:0]       acc_r;
`endif
  logic [NUM_VOICES-1:0][15:0]   prods;
  logic [NUM_VOICES-1:0]         step;
  logic [15:0]                   sel;
  logic signed [ACC_W-1:0]       ext;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign step[v] = (state == S_CALC) && (idx == IDX_W'(v));
    tone_synth_voice #(.PHASE_W(PHASE_W), .AMP_W(AMP_W)) u_voice (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .step      (step[v]),
      .en        (voice_en[v]),
      .phase_inc (phase_inc[v*PHASE_W +: PHASE_W]),
      .wave_sel  (wave_sel[v*2 +: 2]),
      .amplitude (amplitude[v*AMP_W +: AMP_W]),
      .prod      (prods[v])
    );
  end

  assign sel = prods[idx];
  assign ext = {{(ACC_W-16){sel[15]}}, sel};

  // Clamp to 16 bits and left-justify into the codec word.
  function automatic logic [DATA_W-1:0] to_wd(input logic signed [ACC_W-1:0] a);
    logic [15:0] s16;
    if (a > MAXV)      s16 = 16'h7FFF;
    else if (a < MINV) s16 = 16'h8000;
    else               s16 = a[15:0];
    return DATA_W'(s16) << (DATA_W - 16);
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      idx             <= '0;
      acc_l           <= '0;
`ifdef TONE_SYNTH_STEREO_PAN_EN
      acc_r           <= '0;
`endif
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      busy            <= 1'b0;
      sample_count    <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          state <= S_CALC;
          idx   <= '0;
          acc_l <= '0;
`ifdef TONE_SYNTH_STEREO_PAN_EN
          acc_r <= '0;
`endif
          busy  <= 1'b1;
        end
        S_CALC: begin
`ifdef TONE_SYNTH_STEREO_PAN_EN
          if (pan[idx]) acc_r <= acc_r + ext;
          else          acc_l <= acc_l + ext;
`else
          acc_l <= acc_l + ext;
`endif
          if (idx == IDX_W'(NUM_VOICES - 1)) state <= S_SAT;
          else                               idx   <= idx + IDX_W'(1);
        end
        S_SAT: begin
          writedata_left  <= to_wd(acc_l);
`ifdef TONE_SYNTH_STEREO_PAN_EN
          writedata_right <= to_wd(acc_r);
`else
          writedata_right <= to_wd(acc_l);
`endif
          state <= S_HOLD;
        end
        S_HOLD: if (write_ready) begin
          state <= S_WRITE;
          write <= 1'b1;
        end
        S_WRITE: begin
          write        <= 1'b0;
          sample_count <= sample_count + 16'd1;
          if (enable) begin
            state <= S_CALC;
            idx   <= '0;
            acc_l <= '0;
`ifdef TONE_SYNTH_STEREO_PAN_EN
            acc_r <= '0;
`endif
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_synth_writer.sv
// Randomized bench for tone_synth_writer against a per-sample arithmetic model.
module tb_tone_synth_writer;
  localparam int NV = 4, DW = 24, PW = 24, AW = 8;

  logic CLOCK_50 = 1'b0, resetn = 1'b0, enable = 1'b0, write_ready = 1'b0;
  logic [NV-1:0]    voice_en = '0;
  logic [NV*PW-1:0] phase_inc = '0;
  logic [NV*2-1:0]  wave_sel = '0;
  logic [NV*AW-1:0] amplitude = '0;
  logic             write, busy;
  logic [DW-1:0]    writedata_left, writedata_right;
  logic [15:0]      sample_count;

  tone_synth_writer #(.NUM_VOICES(NV), .DATA_W(DW), .PHASE_W(PW), .AMP_W(AW)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .voice_en(voice_en),
    .phase_inc(phase_inc), .wave_sel(wave_sel), .amplitude(amplitude),
    .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
    .writedata_right(writedata_right), .busy(busy), .sample_count(sample_count));

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors = 0, miscompares = 0;
  int ph[NV];
  bit c_en[NV];
  int c_inc[NV], c_ws[NV], c_amp[NV];
  logic [15:0] cnt_exp;
  bit rand_rdy = 0;

  function automatic int wave_val(int t, int ws);
    case (ws)
      0:       return (t >= 128) ? -128 : 127;
      1:       return t - 128;
      2:       return (t < 128) ? 2*t - 128 : 127 - 2*(t - 128);
      default: return 0;
    endcase
  endfunction

  // Mix one sample from the current phases, then advance the phases.
  function automatic logic [DW-1:0] model_next();
    int sum = 0;
    int p;
    for (int i = 0; i < NV; i++) begin
      if (!c_en[i]) ph[i] = 0;
      else begin
        p = (wave_val((ph[i] >> (PW-8)) & 255, c_ws[i]) * c_amp[i]) >>> (AW-8);
        p = int'(shortint'(p));
        sum += p;
        ph[i] = (ph[i] + c_inc[i]) % (1 << PW);
      end
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return DW'(sum & 32'hFFFF) << (DW-16);
  endfunction

  task automatic drive_cfg();
    for (int i = 0; i < NV; i++) begin
      voice_en[i]            = c_en[i];
      phase_inc[i*PW +: PW]  = PW'(c_inc[i]);
      wave_sel[i*2 +: 2]     = 2'(c_ws[i]);
      amplitude[i*AW +: AW]  = AW'(c_amp[i]);
    end
  endtask

  task automatic set_all(bit en, int ws, int amp, int inc);
    for (int i = 0; i < NV; i++) begin
      c_en[i] = en; c_ws[i] = ws; c_amp[i] = amp; c_inc[i] = inc;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) ph[i] = 0;
    cnt_exp = '0;
  endtask

  task automatic do_reset();
    enable = 0; resetn = 0;
    @(negedge CLOCK_50); @(negedge CLOCK_50);
    resetn = 1;
    model_reset();
  endtask

  task automatic wait_write(output bit got, output int cyc);
    got = 0; cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge CLOCK_50);
      if (write === 1'b1) begin got = 1; cyc = c; return; end
      if (rand_rdy) write_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    bit got; int cyc; logic [DW-1:0] e;
    set_all(0, 0, 0, 0);
    c_en[0] = 1; c_ws[0] = 0; c_amp[0] = 255; c_inc[0] = 'h800000;
    drive_cfg();
    enable = 1; write_ready = 1; resetn = 0;
    model_reset();
    @(negedge CLOCK_50); @(negedge CLOCK_50);
    vectors++;
    if (write !== 0 || writedata_left !== 0 || writedata_right !== 0 || sample_count !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL reset_state: write=%b l=%h r=%h cnt=%0d busy=%b, want all zero",
               write, writedata_left, writedata_right, sample_count, busy);
    end
    resetn = 1;
    wait_write(got, cyc);
    vectors++;
    if (!got || cyc != 1 + NV + 2) begin
      miscompares++;
      $display("FAIL reset_latency: write after %0d cycles (seen=%0b), want %0d", cyc, got, 1 + NV + 2);
    end
    e = model_next();
    vectors++;
    if (writedata_left !== e || writedata_right !== e || writedata_left !== 24'h7E8100 || sample_count !== cnt_exp) begin
      miscompares++;
      $display("FAIL first_sample: l=%h r=%h cnt=%0d, want %h cnt=%0d",
               writedata_left, writedata_right, sample_count, e, cnt_exp);
    end
    cnt_exp++;
  endtask

  task automatic test_square_back_to_back();
    bit got; int cyc; logic [DW-1:0] e;
    for (int k = 0; k < 6; k++) begin
      wait_write(got, cyc);
      if (k == 5) enable = 0;
      e = model_next();
      vectors++;
      if (!got || cyc != NV + 3 || writedata_left !== e || writedata_right !== e || sample_count !== cnt_exp) begin
        miscompares++;
        $display("FAIL square_b2b[%0d]: gap=%0d l=%h r=%h cnt=%0d, want gap=%0d data=%h cnt=%0d",
                 k, cyc, writedata_left, writedata_right, sample_count, NV + 3, e, cnt_exp);
      end
      cnt_exp++;
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_saturation();
    bit got; int cyc; logic [DW-1:0] e;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      set_all(1, pass, 255, 0);
      drive_cfg();
      write_ready = 1; enable = 1;
      for (int k = 0; k < 3; k++) begin
        wait_write(got, cyc);
        if (k == 2) enable = 0;
        e = model_next();
        vectors++;
        if (!got || writedata_left !== e || writedata_right !== e ||
            writedata_left !== ((pass == 0) ? 24'h7FFF00 : 24'h800000)) begin
          miscompares++;
          $display("FAIL saturation[%0d.%0d]: l=%h r=%h, want %h", pass, k, writedata_left, writedata_right, e);
        end
        cnt_exp++;
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_saw();
    bit got; int cyc; logic [DW-1:0] e;
    do_reset();
    set_all(0, 0, 0, 0);
    c_en[0] = 1; c_ws[0] = 1; c_amp[0] = 1; c_inc[0] = 'h010000;
    drive_cfg();
    write_ready = 1; enable = 1;
    for (int k = 0; k <= 256; k++) begin
      wait_write(got, cyc);
      if (k == 256) enable = 0;
      e = model_next();
      vectors++;
      if (!got || writedata_left !== e || writedata_right !== e || sample_count !== cnt_exp ||
          ((k == 0 || k == 256) && writedata_left !== 24'hFF8000)) begin
        miscompares++;
        $display("FAIL saw[%0d]: l=%h r=%h cnt=%0d, want %h cnt=%0d",
                 k, writedata_left, writedata_right, sample_count, e, cnt_exp);
      end
      cnt_exp++;
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_backpressure();
    bit got; int cyc; logic [DW-1:0] e;
    set_all(0, 0, 0, 0);
    c_en[0] = 1; c_ws[0] = 0; c_amp[0] = 200; c_inc[0] = 'h400000;
    c_en[1] = 1; c_ws[1] = 2; c_amp[1] = 90;  c_inc[1] = 'h123456;
    drive_cfg();
    write_ready = 0; enable = 1;
    repeat (NV + 4) @(negedge CLOCK_50);
    e = model_next();
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50);
      vectors++;
      if (write !== 0 || busy !== 1 || writedata_left !== e || writedata_right !== e) begin
        miscompares++;
        $display("FAIL hold[%0d]: write=%b busy=%b l=%h r=%h, want 0 1 %h", k, write, busy,
                 writedata_left, writedata_right, e);
      end
    end
    write_ready = 1;
    wait_write(got, cyc);
    write_ready = 0; enable = 0;
    vectors++;
    if (!got || cyc != 1 || writedata_left !== e || sample_count !== cnt_exp) begin
      miscompares++;
      $display("FAIL release: gap=%0d l=%h cnt=%0d, want gap=1 %h cnt=%0d", cyc, writedata_left,
               sample_count, e, cnt_exp);
    end
    cnt_exp++;
    @(negedge CLOCK_50);
    vectors++;
    if (write !== 0 || sample_count !== cnt_exp || busy !== 0) begin
      miscompares++;
      $display("FAIL after_pulse: write=%b cnt=%0d busy=%b, want 0 %0d 0", write, sample_count, busy, cnt_exp);
    end
  endtask

  task automatic test_enable_drop();
    bit got; int cyc; logic [DW-1:0] e;
    int extra = 0;
    write_ready = 1; enable = 1;
    wait_write(got, cyc);
    e = model_next();
    vectors++;
    if (!got || writedata_left !== e) begin
      miscompares++;
      $display("FAIL drop_first: l=%h, want %h", writedata_left, e);
    end
    cnt_exp++;
    @(negedge CLOCK_50); @(negedge CLOCK_50);
    enable = 0;
    wait_write(got, cyc);
    e = model_next();
    vectors++;
    if (!got || writedata_left !== e || sample_count !== cnt_exp) begin
      miscompares++;
      $display("FAIL drop_last: seen=%0b l=%h cnt=%0d, want %h cnt=%0d", got, writedata_left,
               sample_count, e, cnt_exp);
    end
    cnt_exp++;
    @(negedge CLOCK_50);
    for (int k = 0; k < 20; k++) begin
      if (write === 1'b1) extra++;
      @(negedge CLOCK_50);
    end
    vectors++;
    if (busy !== 0 || extra != 0) begin
      miscompares++;
      $display("FAIL drop_idle: busy=%b extra_writes=%0d, want 0 0", busy, extra);
    end
  endtask

  task automatic test_reset_in_hold();
    bit got; int cyc; logic [DW-1:0] e;
    set_all(0, 0, 0, 0);
    c_en[0] = 1; c_ws[0] = 0; c_amp[0] = 255; c_inc[0] = 'h300000;
    c_en[2] = 1; c_ws[2] = 1; c_amp[2] = 77;  c_inc[2] = 'h0ABCDE;
    drive_cfg();
    write_ready = 0; enable = 1;
    repeat (NV + 6) @(negedge CLOCK_50);
    e = model_next();
    vectors++;
    if (busy !== 1 || writedata_left !== e) begin
      miscompares++;
      $display("FAIL pre_reset_hold: busy=%b l=%h, want 1 %h", busy, writedata_left, e);
    end
    #2 resetn = 0;
    #1;
    vectors++;
    if (write !== 0 || busy !== 0 || writedata_left !== 0 || writedata_right !== 0 || sample_count !== 0) begin
      miscompares++;
      $display("FAIL reset_in_hold: write=%b busy=%b l=%h r=%h cnt=%0d, want all zero",
               write, busy, writedata_left, writedata_right, sample_count);
    end
    model_reset();
    @(negedge CLOCK_50);
    resetn = 1; write_ready = 1;
    wait_write(got, cyc);
    enable = 0;
    e = model_next();
    vectors++;
    if (!got || writedata_left !== e || writedata_right !== e || sample_count !== cnt_exp) begin
      miscompares++;
      $display("FAIL post_reset_sample: l=%h r=%h cnt=%0d, want %h cnt=%0d", writedata_left,
               writedata_right, sample_count, e, cnt_exp);
    end
    cnt_exp++;
    @(negedge CLOCK_50);
  endtask

  task automatic test_random();
    bit got; int cyc; logic [DW-1:0] e;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NV; i++) begin
        c_en[i]  = 1'($urandom_range(0, 1));
        c_ws[i]  = $urandom_range(0, 3);
        c_amp[i] = $urandom_range(0, 255);
        c_inc[i] = $urandom_range(0, (1 << PW) - 1);
      end
      drive_cfg();
      rand_rdy = 1; enable = 1;
      for (int k = 0; k < 6; k++) begin
        wait_write(got, cyc);
        if (k == 5) begin enable = 0; rand_rdy = 0; write_ready = 0; end
        e = model_next();
        vectors++;
        if (!got || writedata_left !== e || writedata_right !== e || sample_count !== cnt_exp) begin
          miscompares++;
          $display("FAIL random[%0d.%0d]: seen=%0b l=%h r=%h cnt=%0d, want %h cnt=%0d", r, k, got,
                   writedata_left, writedata_right, sample_count, e, cnt_exp);
        end
        cnt_exp++;
      end
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    test_reset();
    test_square_back_to_back();
    test_saturation();
    test_saw();
    test_backpressure();
    test_enable_drop();
    test_reset_in_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
